mul_pipeline: RTL and testbench



---
 rtl/params_pkg.sv | 14 +
 rtl/mul_partial_products.sv | 23 ++
 rtl/mul_pipeline.sv | 114 +++++++++++
 tb/tb_mul_pipeline.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared core parameters and the per-stage record of the multiply pipe.
package params_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REGISTER_WIDTH = 5;
    localparam int unsigned MUL_STAGES     = 5;

    typedef struct packed {
        logic                      valid;
        logic [REGISTER_WIDTH-1:0] wr_reg;
        logic [DATA_WIDTH-1:0]     prod;
    } mul_stage_t;

endpackage

// File: rtl/mul_partial_products.sv
// Combinational half-width partial products feeding the ex1 registers of mul_pipeline.
module mul_partial_products #(
    parameter int unsigned DATA_WIDTH = params_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0]   pp_ll_o,
    output logic [DATA_WIDTH/2-1:0] pp_x_o
);

    localparam int unsigned H = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] a_lo_ext;
    logic [DATA_WIDTH-1:0] b_lo_ext;

    assign a_lo_ext = {{H{1'b0}}, a_i[H-1:0]};
    assign b_lo_ext = {{H{1'b0}}, b_i[H-1:0]};

    assign pp_ll_o = a_lo_ext * b_lo_ext;
    // Only the low H bits of the cross terms survive the final shift by H.
    assign pp_x_o  = a_i[H-1:0] * b_i[DATA_WIDTH-1:H] + a_i[DATA_WIDTH-1:H] * b_i[H-1:0];

endmodule

// File: rtl/mul_pipeline.sv
// Fixed-latency pipelined multiplier (ex1..exN) with per-stage valid/destination tags.
// Optional MUL_PIPE_PERF_EN adds issue and stall performance counters.
module mul_pipeline #(
    parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int unsigned NUM_STAGES     = params_pkg::MUL_STAGES
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          valid_i,
    input  logic [DATA_WIDTH-1:0]                         rs1_data_i,
    input  logic [DATA_WIDTH-1:0]                         rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0]                     wr_reg_i,
    input  logic                                          flush_i,
    input  logic                                          wb_ready_i,
    output logic                                          ready_o,
    output logic [NUM_STAGES-1:0]                         stage_valid_o,
    output logic [NUM_STAGES-1:0][REGISTER_WIDTH-1:0]     stage_wr_reg_o,
    output logic [DATA_WIDTH-1:0]                         result_o
`ifdef MUL_PIPE_PERF_EN
    ,
    output logic [31:0]                                   perf_issued_o,
    output logic [31:0]                                   perf_stall_o
`endif
);

    localparam int unsigned H = DATA_WIDTH / 2;

    logic                  stall;
    logic                  issue;
    logic [DATA_WIDTH-1:0] pp_ll_d;
    logic [H-1:0]          pp_x_d;
    logic [DATA_WIDTH-1:0] ex2_prod;

    // ex1 holds partial products rather than a product.
    logic                      ex1_valid_q;
    logic [REGISTER_WIDTH-1:0] ex1_wr_reg_q;
    logic [DATA_WIDTH-1:0]     pp_ll_q;
    logic [H-1:0]              pp_x_q;

    logic [NUM_STAGES-1:1]                     valid_q;
    logic [NUM_STAGES-1:1][REGISTER_WIDTH-1:0] wr_reg_q;
    logic [NUM_STAGES-1:1][DATA_WIDTH-1:0]     prod_q;

    assign stall    = valid_q[NUM_STAGES-1] && !wb_ready_i;
    assign ready_o  = !stall;
    assign issue    = valid_i && ready_o && !flush_i;
    assign ex2_prod = pp_ll_q + {pp_x_q, {H{1'b0}}};

    mul_partial_products #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_partial_products (
        .a_i     (rs1_data_i),
        .b_i     (rs2_data_i),
        .pp_ll_o (pp_ll_d),
        .pp_x_o  (pp_x_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ex1_valid_q  <= 1'b0;
            ex1_wr_reg_q <= '0;
            pp_ll_q      <= '0;
            pp_x_q       <= '0;
            valid_q      <= '0;
            wr_reg_q     <= '0;
            prod_q       <= '0;
        end else if (!stall) begin
            ex1_valid_q  <= issue;
            ex1_wr_reg_q <= issue ? wr_reg_i : '0;
            pp_ll_q      <= issue ? pp_ll_d : '0;
            pp_x_q       <= issue ? pp_x_d : '0;
            valid_q[1]   <= ex1_valid_q;
            wr_reg_q[1]  <= ex1_wr_reg_q;
            prod_q[1]    <= ex2_prod;
            for (int k = 2; k < int'(NUM_STAGES); k++) begin
                valid_q[k]  <= valid_q[k-1];
                wr_reg_q[k] <= wr_reg_q[k-1];
                prod_q[k]   <= prod_q[k-1];
            end
        end
    end

    always_comb begin
        stage_wr_reg_o    = '0;
        stage_wr_reg_o[0] = ex1_wr_reg_q;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            stage_wr_reg_o[k] = wr_reg_q[k];
        end
    end

    assign stage_valid_o = {valid_q, ex1_valid_q};
    assign result_o      = prod_q[NUM_STAGES-1];

`ifdef MUL_PIPE_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;

    // Flush deliberately leaves the counters running.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue) perf_issued_q <= perf_issued_q + 32'd1;
            if (stall) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_pipeline.sv
// Directed plus randomized bench for mul_pipeline against an op-list reference model.
module tb_mul_pipeline;

    localparam int N  = params_pkg::MUL_STAGES;
    localparam int DW = params_pkg::DATA_WIDTH;
    localparam int RW = params_pkg::REGISTER_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      valid_i = 1'b0;
    logic [DW-1:0]             rs1_data_i = '0;
    logic [DW-1:0]             rs2_data_i = '0;
    logic [RW-1:0]             wr_reg_i = '0;
    logic                      flush_i = 1'b0;
    logic                      wb_ready_i = 1'b1;
    logic                      ready_o;
    logic [N-1:0]              stage_valid_o;
    logic [N-1:0][RW-1:0]      stage_wr_reg_o;
    logic [DW-1:0]             result_o;
`ifdef MUL_PIPE_PERF_EN
    logic [31:0]               perf_issued_o;
    logic [31:0]               perf_stall_o;
`endif

    mul_pipeline dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .wr_reg_i       (wr_reg_i),
        .flush_i        (flush_i),
        .wb_ready_i     (wb_ready_i),
        .ready_o        (ready_o),
        .stage_valid_o  (stage_valid_o),
        .stage_wr_reg_o (stage_wr_reg_o),
        .result_o       (result_o)
`ifdef MUL_PIPE_PERF_EN
        ,
        .perf_issued_o  (perf_issued_o),
        .perf_stall_o   (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: list of in-flight ops, each with its current stage index.
    typedef struct {
        int            pos;
        logic [RW-1:0] rd;
        logic [DW-1:0] prod;
    } op_t;

    op_t         ops[$];
    logic [31:0] m_issued = 0;
    logic [31:0] m_stalls = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall(input bit wb);
        foreach (ops[i]) if (ops[i].pos == N - 1 && !wb) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit rs, input bit fl, input bit v, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [RW-1:0] rd, input bit wb);
        bit st;
        st = model_stall(wb);
        if (rs) begin
            m_issued = 0;
            m_stalls = 0;
        end else begin
            if (v && !st && !fl) m_issued = m_issued + 1;
            if (st) m_stalls = m_stalls + 1;
        end
        if (rs || fl) begin
            ops.delete();
        end else if (!st) begin
            foreach (ops[i]) ops[i].pos++;
            if (ops.size() > 0 && ops[0].pos >= N) void'(ops.pop_front());
            if (v) ops.push_back('{0, rd, DW'(64'(a) * 64'(b))});
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]     ev;
        logic [N*RW-1:0]  ew;
        logic [DW-1:0]    er;
        ev = '0;
        ew = '0;
        er = '0;
        foreach (ops[i]) begin
            ev[ops[i].pos] = 1'b1;
            ew[ops[i].pos*RW +: RW] = ops[i].rd;
            if (ops[i].pos == N - 1) er = ops[i].prod;
        end
        chk("stage_valid", 64'(stage_valid_o), 64'(ev));
        chk("stage_wr_reg", 64'(stage_wr_reg_o), 64'(ew));
        chk("result", 64'(result_o), 64'(er));
`ifdef MUL_PIPE_PERF_EN
        chk("perf_issued", 64'(perf_issued_o), 64'(m_issued));
        chk("perf_stall", 64'(perf_stall_o), 64'(m_stalls));
`endif
    endtask

    // Drive one cycle: inputs after the edge, ready_o checked mid-cycle, state checked after.
    task automatic cycle(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] rd, input bit fl, input bit wb, input bit rs);
        valid_i    = v;
        rs1_data_i = a;
        rs2_data_i = b;
        wr_reg_i   = rd;
        flush_i    = fl;
        wb_ready_i = wb;
        rst_i      = rs;
        @(negedge clk);
        chk("ready", 64'(ready_o), 64'(!model_stall(wb)));
        model_edge(rs, fl, v, a, b, rd, wb);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit wb);
        cycle(1'b0, '0, '0, '0, 1'b0, wb, 1'b0);
    endtask

    initial begin
        // Reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        chk("reset_ready", 64'(ready_o), 64'd1);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);

        // Single op walks through all stages
        cycle(1'b1, 32'd3, 32'd7, 5'd5, 1'b0, 1'b1, 1'b0);
        chk("walk_valid_0", 64'(stage_valid_o), 64'd1);
        for (int i = 1; i < N; i++) begin
            idle(1'b1);
            chk("walk_valid", 64'(stage_valid_o), 64'd1 << i);
        end
        chk("walk_wr_reg", 64'(stage_wr_reg_o[N-1]), 64'd5);
        chk("walk_result", 64'(result_o), 64'd21);
        idle(1'b1);

        // Back-to-back corner products
        cycle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("b2b_res0", 64'(result_o), 64'h0000_0001);
        idle(1'b1);
        chk("b2b_res1", 64'(result_o), 64'h0000_0000);
        chk("b2b_res1_valid", 64'(stage_valid_o[N-1]), 64'd1);
        idle(1'b1);
        chk("b2b_res2", 64'(result_o), 64'h242D_2080);
        for (int i = 0; i < N; i++) idle(1'b1);

        // wb_ready low with empty last stage, then a 3-cycle stall with valid_i held high
        cycle(1'b1, 32'd11, 32'd13, 5'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < N; i++) idle(1'b0);
        chk("stall_last_valid", 64'(stage_valid_o[N-1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'd2, 32'd2, 5'd4, 1'b0, 1'b0, 1'b0);
            chk("stall_ready", 64'(ready_o), 64'd0);
            chk("stall_result", 64'(result_o), 64'd143);
        end
        idle(1'b1);
        for (int i = 0; i < N; i++) idle(1'b1);

        // Flush with simultaneous issue
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i + 4), 32'd5, 5'(i + 10), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'd9, 32'd9, 5'd20, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(stage_valid_o), 64'd0);
        chk("flush_ready", 64'(ready_o), 64'd1);

        // Reset with ops in ex2 and ex4
        cycle(1'b1, 32'd6, 32'd6, 5'd7, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        cycle(1'b1, 32'd8, 32'd8, 5'd8, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        cycle(1'b1, 32'd1, 32'd1, 5'd1, 1'b0, 1'b1, 1'b1);
        chk("rst_valid", 64'(stage_valid_o), 64'd0);
        chk("rst_wr_reg", 64'(stage_wr_reg_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);

`ifdef MUL_PIPE_PERF_EN
        chk("perf_rst_issued", 64'(perf_issued_o), 64'd0);
        chk("perf_rst_stall", 64'(perf_stall_o), 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i), 32'd3, 5'(i), 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        chk("perf_issued4", 64'(perf_issued_o), 64'd4);
        chk("perf_stall2", 64'(perf_stall_o), 64'd2);
        for (int i = 0; i < N; i++) idle(1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0001_0000 : $urandom;
            cycle(1'($urandom_range(0, 3) != 0), a, b, 5'($urandom),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
